// File: rtl/config_frame_shadow_mem_if.sv
// Frame-load / commit bus between the fabric frame distributor and one tile's config store.
// Latency: none, this is wiring only.
// Backpressure: FrameReady from the slave stalls the frame source.
// Optional: CONFIG_READBACK_EN adds ReadAddr/ReadData for active-frame readback.
interface config_frame_shadow_mem_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 640,
  parameter int FrameAddrWidth  = 5
);
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [FrameAddrWidth-1:0]  FrameAddr;
  logic                       FrameValid;
  logic                       FrameReady;
  logic                       Commit;
  logic                       CommitDone;
  logic                       AddrError;
  logic [FrameAddrWidth:0]    FramesWritten;
  logic [NoConfigBits-1:0]    ConfigBits;
  logic [NoConfigBits-1:0]    ConfigBits_N;
`ifdef CONFIG_READBACK_EN
  logic [FrameAddrWidth-1:0]  ReadAddr;
  logic [FrameBitsPerRow-1:0] ReadData;
`endif

  // Frame source / configuration controller side.
  modport master (
    output FrameData, FrameAddr, FrameValid, Commit,
`ifdef CONFIG_READBACK_EN
    output ReadAddr,
    input  ReadData,
`endif
    input  FrameReady, CommitDone, AddrError, FramesWritten, ConfigBits, ConfigBits_N
  );

  // Config store side.
  modport slave (
    input  FrameData, FrameAddr, FrameValid, Commit,
`ifdef CONFIG_READBACK_EN
    input  ReadAddr,
    output ReadData,
`endif
    output FrameReady, CommitDone, AddrError, FramesWritten, ConfigBits, ConfigBits_N
  );
endinterface

// File: rtl/config_frame_shadow_mem.sv
// Shadow frame store with atomic commit of the whole array into the active ConfigBits.
// Latency: frame lands in shadow on its accepting edge; Commit at edge t gives new ConfigBits and CommitDone after edge t+1.
// Backpressure: FrameReady is low only during the single COMMIT cycle and while resetn is low.
// Optional: define CONFIG_READBACK_EN for a registered ReadAddr -> ReadData view of the active frames.
module config_frame_shadow_mem #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 640,
  parameter int FrameAddrWidth  = 5
) (
  input logic                      CLK,
  input logic                      resetn,
  config_frame_shadow_mem_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_t;

  state_t                  state;
  logic [NoConfigBits-1:0] shadow;
  logic [NoConfigBits-1:0] configBits;
  logic [NoConfigBits-1:0] configBitsN;
  logic [FrameAddrWidth:0] framesWritten;
  logic                    addrError;
  logic                    commitDone;
  logic                    frameReady;
  logic                    accept;
  logic                    addrInRange;

  // Ready is a pure decode of the state register, forced low while reset is held.
  assign frameReady  = resetn && (state != StCommit);
  assign accept      = bus.FrameValid && frameReady;
  assign addrInRange = {1'b0, bus.FrameAddr} < (FrameAddrWidth+1)'(MaxFramesPerCol);

  // Only rows that map onto used config indices get storage; a partial last row keeps its low bits.
  for (genvar f = 0; f < MaxFramesPerCol; f++) begin : gRow
    localparam int Lo = f * FrameBitsPerRow;
    if (Lo < NoConfigBits) begin : gStored
      localparam int W = (NoConfigBits - Lo < FrameBitsPerRow) ? (NoConfigBits - Lo) : FrameBitsPerRow;
      // Overwrite this shadow row on an accepted write addressed to it; last write wins.
      always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
          shadow[Lo +: W] <= '0;
        end else if (accept && addrInRange && (bus.FrameAddr == FrameAddrWidth'(f))) begin
          shadow[Lo +: W] <= bus.FrameData[W-1:0];
        end
      end
    end
  end

  // Load/commit sequencing: active bits move only on the edge closing the COMMIT cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= StIdle;
      configBits    <= '0;
      configBitsN   <= '1;
      commitDone    <= 1'b0;
      addrError     <= 1'b0;
      framesWritten <= '0;
    end else begin
      commitDone <= 1'b0;
      if (accept) begin
        if (!addrInRange) begin
          addrError <= 1'b1;
        end else if (framesWritten != '1) begin
          framesWritten <= framesWritten + (FrameAddrWidth+1)'(1);
        end
      end
      case (state)
        StIdle: begin
          if (bus.Commit) begin
            state <= StCommit;
          end else if (accept) begin
            state <= StLoad;
          end
        end
        StLoad: begin
          if (bus.Commit) begin
            state <= StCommit;
          end
        end
        StCommit: begin
          configBits    <= shadow;
          configBitsN   <= ~shadow;
          commitDone    <= 1'b1;
          framesWritten <= '0;
          addrError     <= 1'b0;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.FrameReady    = frameReady;
  assign bus.CommitDone    = commitDone;
  assign bus.AddrError     = addrError;
  assign bus.FramesWritten = framesWritten;
  assign bus.ConfigBits    = configBits;
  assign bus.ConfigBits_N  = configBitsN;

`ifdef CONFIG_READBACK_EN
  localparam int PadBits = MaxFramesPerCol * FrameBitsPerRow;

  logic [PadBits-1:0]         activePad;
  logic [FrameBitsPerRow-1:0] readNext;
  logic [FrameBitsPerRow-1:0] readData;

  // Positions beyond NoConfigBits read back as zero.
  assign activePad = PadBits'(configBits);

  // Select the addressed active frame; out-of-range addresses fall through to zero.
  always_comb begin
    readNext = '0;
    for (int f = 0; f < MaxFramesPerCol; f++) begin
      if (bus.ReadAddr == FrameAddrWidth'(f)) begin
        readNext = activePad[f*FrameBitsPerRow +: FrameBitsPerRow];
      end
    end
  end

  // Register the readback one cycle after the address, independent of the FSM.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      readData <= '0;
    end else begin
      readData <= readNext;
    end
  end

  assign bus.ReadData = readData;
`endif

endmodule

// File: tb/tb_config_frame_shadow_mem.sv
// Randomized scoreboard bench for config_frame_shadow_mem against a frame-array reference model.
// Latency: checks the two-edge Commit to CommitDone timing and one-cycle FrameReady drop.
// Backpressure: frame writes wait (bounded) for FrameReady before counting as accepted.
module tb_config_frame_shadow_mem;
  localparam int Frames = 20;
  localparam int Bits   = 32;
  localparam int NCfg   = 640;
  localparam int AW     = 5;
  localparam int FwMax  = (1 << (AW + 1)) - 1;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  always #5 CLK = ~CLK;

  config_frame_shadow_mem_if #(.FrameBitsPerRow(Bits), .NoConfigBits(NCfg), .FrameAddrWidth(AW)) bus();

  config_frame_shadow_mem #(
    .MaxFramesPerCol(Frames), .FrameBitsPerRow(Bits), .NoConfigBits(NCfg), .FrameAddrWidth(AW)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int doneSeen = 0;

  // Reference model: plain frame array, committed image, counters.
  logic [Bits-1:0] shadowM [Frames];
  logic [NCfg-1:0] activeM;
  logic [NCfg-1:0] monExp;
  logic [NCfg-1:0] expQ [$];
  int              fwM;
  bit              aeM;

  task automatic check(input string name, input logic [NCfg-1:0] act, input logic [NCfg-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NCfg-1:0] packShadow();
    logic [NCfg-1:0] v;
    v = '0;
    for (int f = 0; f < Frames; f++)
      for (int b = 0; b < Bits; b++)
        if (f * Bits + b < NCfg) v[f*Bits+b] = shadowM[f][b];
    return v;
  endfunction

  task automatic modelReset();
    for (int f = 0; f < Frames; f++) shadowM[f] = '0;
    activeM = '0;
    fwM = 0;
    aeM = 1'b0;
  endtask

  task automatic modelWrite(input int addr, input logic [Bits-1:0] data);
    if (addr < Frames) begin
      shadowM[addr] = data;
      fwM = (fwM < FwMax) ? fwM + 1 : FwMax;
    end else begin
      aeM = 1'b1;
    end
  endtask

  // Monitor: every CommitDone pulse pops one expected image and checks both polarities.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.CommitDone === 1'b1) begin
        if (expQ.size() == 0) begin
          check("unexpected_commit_done", NCfg'(1), NCfg'(0));
        end else begin
          monExp = expQ.pop_front();
          check("config_bits", bus.ConfigBits, monExp);
          check("config_bits_n", bus.ConfigBits_N, ~monExp);
        end
        doneSeen++;
      end
    end
  end

  task automatic writeFrame(input int addr, input logic [Bits-1:0] data);
    bit accepted;
    accepted = 1'b0;
    @(posedge CLK); #1;
    bus.FrameValid = 1'b1;
    bus.FrameAddr  = AW'(addr);
    bus.FrameData  = data;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge CLK);
      if (bus.FrameReady === 1'b1) begin
        @(posedge CLK);
        accepted = 1'b1;
      end
    end
    if (accepted) modelWrite(addr, data);
    else check("write_accept_timeout", NCfg'(0), NCfg'(1));
    #1 bus.FrameValid = 1'b0;
  endtask

  task automatic doCommit(input bit withWrite, input int addr, input logic [Bits-1:0] data);
    logic [NCfg-1:0] prev;
    int start;
    start = doneSeen;
    @(posedge CLK); #1;
    bus.Commit = 1'b1;
    if (withWrite) begin
      bus.FrameValid = 1'b1;
      bus.FrameAddr  = AW'(addr);
      bus.FrameData  = data;
    end
    @(negedge CLK);
    check("ready_before_commit", NCfg'(bus.FrameReady), NCfg'(1));
    @(posedge CLK);
    if (withWrite) modelWrite(addr, data);
    fwM = 0;
    aeM = 1'b0;
    prev = activeM;
    activeM = packShadow();
    expQ.push_back(activeM);
    #1;
    bus.Commit = 1'b0;
    bus.FrameValid = 1'b0;
    @(negedge CLK);
    check("ready_in_commit", NCfg'(bus.FrameReady), NCfg'(0));
    check("bits_held_during_commit", bus.ConfigBits, prev);
    @(negedge CLK); #1;
    check("commit_done_latency", NCfg'(doneSeen - start), NCfg'(1));
    check("ready_after_commit", NCfg'(bus.FrameReady), NCfg'(1));
    check("frames_written_cleared", NCfg'(bus.FramesWritten), NCfg'(fwM));
    check("addr_error_cleared", NCfg'(bus.AddrError), NCfg'(aeM));
  endtask

  task automatic checkCounters(input string tag);
    @(negedge CLK);
    check({tag, "_frames_written"}, NCfg'(bus.FramesWritten), NCfg'(fwM));
    check({tag, "_addr_error"}, NCfg'(bus.AddrError), NCfg'(aeM));
  endtask

`ifdef CONFIG_READBACK_EN
  task automatic readCheck(input int addr);
    logic [Bits-1:0] e;
    @(posedge CLK); #1;
    bus.ReadAddr = AW'(addr);
    @(posedge CLK); #1;
    e = '0;
    if (addr < Frames) e = activeM[addr*Bits +: Bits];
    check("read_data", NCfg'(bus.ReadData), NCfg'(e));
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.FrameValid = 1'b0;
    bus.FrameAddr  = '0;
    bus.FrameData  = '0;
    bus.Commit     = 1'b0;
`ifdef CONFIG_READBACK_EN
    bus.ReadAddr   = '0;
`endif
    modelReset();

    // Reset state.
    @(negedge CLK);
    check("ready_in_reset", NCfg'(bus.FrameReady), NCfg'(0));
    @(posedge CLK); #1;
    resetn = 1'b1;
    repeat (5) @(negedge CLK);
    check("reset_config_bits", bus.ConfigBits, '0);
    check("reset_config_bits_n", bus.ConfigBits_N, '1);
    check("reset_ready", NCfg'(bus.FrameReady), NCfg'(1));
    check("reset_commit_done", NCfg'(bus.CommitDone), NCfg'(0));
    checkCounters("reset");

    // Two frames at both ends of the column, then commit.
    writeFrame(0, 32'hDEADBEEF);
    writeFrame(19, 32'h12345678);
    checkCounters("two_writes");
    check("two_writes_count_is_2", NCfg'(bus.FramesWritten), NCfg'(2));
    doCommit(1'b0, 0, '0);
    check("frame0_bits", NCfg'(bus.ConfigBits[31:0]), NCfg'(32'hDEADBEEF));
    check("frame19_bits", NCfg'(bus.ConfigBits[639:608]), NCfg'(32'h12345678));

    // Out-of-range address is dropped and flagged until the next commit.
    writeFrame(25, 32'hFFFF0000);
    checkCounters("bad_addr");
    check("bad_addr_flag_set", NCfg'(bus.AddrError), NCfg'(1));
    doCommit(1'b0, 0, '0);

    // Write and commit in the same cycle.
    doCommit(1'b1, 3, 32'hA5A5A5A5);
    check("frame3_bits", NCfg'(bus.ConfigBits[127:96]), NCfg'(32'hA5A5A5A5));
    check("frame0_kept", NCfg'(bus.ConfigBits[31:0]), NCfg'(32'hDEADBEEF));

`ifdef CONFIG_READBACK_EN
    readCheck(0);
    readCheck(30);
    readCheck(3);
`endif

    // Empty commit re-applies the shadow.
    doCommit(1'b0, 0, '0);

    // Reset asserted during the COMMIT cycle abandons the commit.
    writeFrame(5, 32'hCAFEF00D);
    @(posedge CLK); #1;
    bus.Commit = 1'b1;
    @(posedge CLK); #1;
    bus.Commit = 1'b0;
    resetn = 1'b0;
    modelReset();
    @(negedge CLK);
    check("abort_bits_zero", bus.ConfigBits, '0);
    check("abort_ready_low", NCfg'(bus.FrameReady), NCfg'(0));
    @(posedge CLK); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_no_commit_done", NCfg'(bus.CommitDone), NCfg'(0));
    end
    check("abort_bits_n_ones", bus.ConfigBits_N, '1);
    check("abort_idle_ready", NCfg'(bus.FrameReady), NCfg'(1));
    checkCounters("abort");
    doCommit(1'b0, 0, '0);

    // Randomized writes, commits and readbacks.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        writeFrame($urandom_range(0, 31), $urandom);
        checkCounters("rand_write");
      end else if (r == 7) begin
        doCommit(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
      end else begin
`ifdef CONFIG_READBACK_EN
        readCheck($urandom_range(0, 31));
`else
        @(posedge CLK);
`endif
      end
    end
    doCommit(1'b0, 0, '0);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", NCfg'(expQ.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
